// File: rtl/sdram_chk_pkg.sv
// Shared types for the SDRAM command-bus checker: command encodings,
// violation codes and per-bank states.
package sdram_chk_pkg;

  // Values are {ras_n, cas_n, we_n}.
  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_NOT_OPEN     = 3'd1,
    ERR_TRCD         = 3'd2,
    ERR_ALREADY_OPEN = 3'd3,
    ERR_TRP          = 3'd4,
    ERR_NOT_IDLE     = 3'd5,
    ERR_TRFC         = 3'd6,
    ERR_REF_LATE     = 3'd7
  } err_e;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_state_e;

  localparam int ERR_W = 7;

  // One-hot sticky bit for a code: code n maps to bit n-1.
  function automatic logic [ERR_W-1:0] err_bit(input err_e code);
    logic [ERR_W-1:0] b;
    b = '0;
    if (code != ERR_NONE) b = ERR_W'(1) << (int'(code) - 1);
    return b;
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One bank's open/close state machine with its tRCD / tRP countdown.
// Only commands already judged legal are applied.
module sdram_bank_tracker
  import sdram_chk_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_apply,
  input  cmd_e        cmd,
  input  logic        hit,
  output bank_state_e state,
  output logic        open
);

  localparam int TMR_MAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  bank_state_e       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              do_act, do_pre;

  assign do_act = cmd_apply && hit && (cmd == CMD_ACT);
  assign do_pre = cmd_apply && hit && (cmd == CMD_PRE);

  always_comb begin
    // NOTE: defaults first so every path assigns state_d/timer_d; no latch inferred.
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      BANK_IDLE: begin
        if (do_act) begin
          if (TRCD <= 1) state_d = BANK_ACTIVE;
          else begin
            state_d = BANK_ACTIVATING;
            timer_d = TMR_W'(TRCD - 1);
          end
        end
      end
      BANK_ACTIVATING, BANK_ACTIVE: begin
        if (do_pre) begin
          if (TRP <= 1) state_d = BANK_IDLE;
          else begin
            state_d = BANK_PRECHARGING;
            timer_d = TMR_W'(TRP - 1);
          end
        end else if (state_q == BANK_ACTIVATING) begin
          // Last countdown edge: a command on the next edge is at distance TRCD.
          if (timer_q <= TMR_W'(1)) state_d = BANK_ACTIVE;
          else                      timer_d = timer_q - 1'b1;
        end
      end
      BANK_PRECHARGING: begin
        // PRE here is legal but deliberately does not restart the countdown.
        if (timer_q <= TMR_W'(1)) state_d = BANK_IDLE;
        else                      timer_d = timer_q - 1'b1;
      end
      default: state_d = BANK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_IDLE;
      timer_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign state = state_q;
  assign open  = (state_q == BANK_ACTIVATING) || (state_q == BANK_ACTIVE);

endmodule

// File: rtl/sdram_cmd_checker.sv
// Protocol checker on the SDRAM command bus: per-bank timing, refresh
// window/interval checks, sticky error flags and saturating command counts.
module sdram_cmd_checker
  import sdram_chk_pkg::*;
#(
  parameter int BA_W     = 2,
  parameter int TRCD     = 3,
  parameter int TRP      = 3,
  parameter int TRFC     = 7,
  parameter int TREF_MAX = 1560,
  parameter int CNT_W    = 16
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_resetn,
  input  logic                  sdram_en,
  input  logic                  sdram_ras_n,
  input  logic                  sdram_cas_n,
  input  logic                  sdram_we_n,
  input  logic [BA_W-1:0]       sdram_ba,
  input  logic                  sdram_a10,
  input  logic                  clr_i,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [BA_W-1:0]       err_bank,
  output logic [ERR_W-1:0]      err_sticky,
  output logic [2**BA_W-1:0]    bank_open,
  output logic [CNT_W-1:0]      cnt_act,
  output logic [CNT_W-1:0]      cnt_rd,
  output logic [CNT_W-1:0]      cnt_wr,
  output logic [CNT_W-1:0]      cnt_ref
);

  localparam int NUM_BANKS = 2**BA_W;
  localparam int RFC_W     = (TRFC > 1) ? $clog2(TRFC + 1) : 1;
  localparam int REF_W     = $clog2(TREF_MAX + 1);

  cmd_e                 cmd;
  logic                 cmd_vld;
  logic                 cmd_apply;
  bank_state_e          bank_state [NUM_BANKS];
  bank_state_e          sel_state;
  logic [NUM_BANKS-1:0] bank_hit;
  logic                 any_busy;
  logic [BA_W-1:0]      busy_bank;
  err_e                 cmd_err;
  logic [BA_W-1:0]      cmd_err_bank;
  logic [RFC_W-1:0]     rfc_cnt;
  logic [REF_W-1:0]     ref_cnt;
  logic                 ref_ok;
  logic                 ref_late;
  err_e                 err_code_q;

  assign cmd     = cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
  assign cmd_vld = sdram_en && (cmd != CMD_NOP) && (cmd != CMD_BST);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_hit[b] = (sdram_ba == BA_W'(b)) || ((cmd == CMD_PRE) && sdram_a10);
    sdram_bank_tracker #(.TRCD(TRCD), .TRP(TRP)) u_bank (
      .clk       (sdram_clk),
      .rst_n     (sdram_resetn),
      .cmd_apply (cmd_apply),
      .cmd       (cmd),
      .hit       (bank_hit[b]),
      .state     (bank_state[b]),
      .open      (bank_open[b])
    );
  end

  assign sel_state = bank_state[sdram_ba];

  // Descending scan so the lowest non-idle bank wins.
  always_comb begin
    any_busy  = 1'b0;
    busy_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_state[b] != BANK_IDLE) begin
        any_busy  = 1'b1;
        busy_bank = BA_W'(b);
      end
    end
  end

  always_comb begin
    cmd_err      = ERR_NONE;
    cmd_err_bank = sdram_ba;
    if (cmd_vld) begin
      if (rfc_cnt != '0) begin
        cmd_err      = ERR_TRFC;
        cmd_err_bank = '0;
      end else begin
        case (cmd)
          CMD_RD, CMD_WR: begin
            if (sel_state == BANK_ACTIVATING)  cmd_err = ERR_TRCD;
            else if (sel_state != BANK_ACTIVE) cmd_err = ERR_NOT_OPEN;
          end
          CMD_ACT: begin
            if (sel_state == BANK_ACTIVATING || sel_state == BANK_ACTIVE)
              cmd_err = ERR_ALREADY_OPEN;
            else if (sel_state == BANK_PRECHARGING)
              cmd_err = ERR_TRP;
          end
          CMD_REF, CMD_LMR: begin
            if (any_busy) begin
              cmd_err      = ERR_NOT_IDLE;
              cmd_err_bank = busy_bank;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // An erroneous command has no effect beyond counting and reporting.
  assign cmd_apply = cmd_vld && (cmd_err == ERR_NONE);
  assign ref_ok    = cmd_apply && (cmd == CMD_REF);
  assign ref_late  = !ref_ok && (ref_cnt == REF_W'(TREF_MAX - 1));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      rfc_cnt <= '0;
      ref_cnt <= '0;
    end else begin
      if (ref_ok)              rfc_cnt <= RFC_W'(TRFC - 1);
      else if (rfc_cnt != '0)  rfc_cnt <= rfc_cnt - 1'b1;

      if (ref_ok)                            ref_cnt <= '0;
      else if (ref_cnt != REF_W'(TREF_MAX))  ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      err_valid  <= 1'b0;
      err_code_q <= ERR_NONE;
      err_bank   <= '0;
      err_sticky <= '0;
    end else begin
      // A command error outranks a coincident REF_LATE, which stays sticky-only.
      if (cmd_err != ERR_NONE) begin
        err_valid  <= 1'b1;
        err_code_q <= cmd_err;
        err_bank   <= cmd_err_bank;
      end else if (ref_late) begin
        err_valid  <= 1'b1;
        err_code_q <= ERR_REF_LATE;
        err_bank   <= '0;
      end else begin
        err_valid  <= 1'b0;
        err_code_q <= ERR_NONE;
        err_bank   <= '0;
      end

      if (clr_i) err_sticky <= '0;
      else       err_sticky <= err_sticky | err_bit(cmd_err)
                               | (ref_late ? err_bit(ERR_REF_LATE) : '0);
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      cnt_act <= '0;
      cnt_rd  <= '0;
      cnt_wr  <= '0;
      cnt_ref <= '0;
    end else if (clr_i) begin
      cnt_act <= '0;
      cnt_rd  <= '0;
      cnt_wr  <= '0;
      cnt_ref <= '0;
    end else if (cmd_vld) begin
      if (cmd == CMD_ACT) cnt_act <= sat_inc(cnt_act);
      if (cmd == CMD_RD)  cnt_rd  <= sat_inc(cnt_rd);
      if (cmd == CMD_WR)  cnt_wr  <= sat_inc(cnt_wr);
      if (cmd == CMD_REF) cnt_ref <= sat_inc(cnt_ref);
    end
  end

  assign err_code = err_code_q;

endmodule

// File: tb/tb_sdram_cmd_checker.sv
// Directed bench for sdram_cmd_checker: one task per scenario, each with
// hand-computed expectations.
`timescale 1ns/1ps
module tb_sdram_cmd_checker;
  import sdram_chk_pkg::*;

  localparam int BA_W  = 2;
  localparam int CNT_W = 16;

  logic             sdram_clk = 1'b0;
  logic             sdram_resetn = 1'b0;
  logic             sdram_en = 1'b0;
  logic             sdram_ras_n = 1'b1;
  logic             sdram_cas_n = 1'b1;
  logic             sdram_we_n = 1'b1;
  logic [BA_W-1:0]  sdram_ba = '0;
  logic             sdram_a10 = 1'b0;
  logic             clr_i = 1'b0;
  logic             err_valid;
  logic [2:0]       err_code;
  logic [BA_W-1:0]  err_bank;
  logic [6:0]       err_sticky;
  logic [3:0]       bank_open;
  logic [CNT_W-1:0] cnt_act, cnt_rd, cnt_wr, cnt_ref;

  int checks = 0;
  int failures = 0;

  sdram_cmd_checker dut (
    .sdram_clk    (sdram_clk),
    .sdram_resetn (sdram_resetn),
    .sdram_en     (sdram_en),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_ba     (sdram_ba),
    .sdram_a10    (sdram_a10),
    .clr_i        (clr_i),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_bank     (err_bank),
    .err_sticky   (err_sticky),
    .bank_open    (bank_open),
    .cnt_act      (cnt_act),
    .cnt_rd       (cnt_rd),
    .cnt_wr       (cnt_wr),
    .cnt_ref      (cnt_ref)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Present one command for exactly one rising edge, then sample 1 ns later.
  task automatic step(input cmd_e c, input logic [BA_W-1:0] ba, input logic a10,
                      input logic clr, input logic en);
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba  = ba;
    sdram_a10 = a10;
    clr_i     = clr;
    sdram_en  = en;
    @(posedge sdram_clk);
    #1;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = CMD_NOP;
    sdram_a10 = 1'b0;
    clr_i     = 1'b0;
    sdram_en  = 1'b1;
  endtask

  task automatic nop(input int n);
    repeat (n) step(CMD_NOP, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    sdram_resetn = 1'b0;
    sdram_en = 1'b1;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = CMD_NOP;
    sdram_ba = '0;
    sdram_a10 = 1'b0;
    clr_i = 1'b0;
    repeat (2) @(posedge sdram_clk);
    @(negedge sdram_clk);
    sdram_resetn = 1'b1;
  endtask

  task automatic test_reset();
    sdram_resetn = 1'b0;
    repeat (2) @(posedge sdram_clk);
    #1;
    checks++;
    if ({err_valid, err_code, err_bank, err_sticky} !== 13'd0) begin
      failures++;
      $display("FAIL reset_err: got v=%0b code=%0d bank=%0d sticky=%b want all 0",
               err_valid, err_code, err_bank, err_sticky);
    end
    checks++;
    if (bank_open !== 4'b0000 || {cnt_act, cnt_rd, cnt_wr, cnt_ref} !== 64'd0) begin
      failures++;
      $display("FAIL reset_state: got open=%b act=%0d rd=%0d wr=%0d ref=%0d want 0",
               bank_open, cnt_act, cnt_rd, cnt_wr, cnt_ref);
    end
  endtask

  task automatic test_trcd();
    do_reset();
    step(CMD_ACT, 2'd1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bank_open !== 4'b0010 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL trcd_act: got open=%b v=%0b want open=0010 v=0", bank_open, err_valid);
    end
    nop(1);
    step(CMD_RD, 2'd1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd2 || err_bank !== 2'd1 || cnt_rd !== 16'd1) begin
      failures++;
      $display("FAIL trcd_early: got v=%0b code=%0d bank=%0d rd=%0d want v=1 code=2 bank=1 rd=1",
               err_valid, err_code, err_bank, cnt_rd);
    end
    checks++;
    if (err_sticky !== 7'b0000010) begin
      failures++;
      $display("FAIL trcd_sticky: got %b want 0000010", err_sticky);
    end
    do_reset();
    step(CMD_ACT, 2'd1, 1'b0, 1'b0, 1'b1);
    nop(2);
    step(CMD_RD, 2'd1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b0 || cnt_rd !== 16'd1) begin
      failures++;
      $display("FAIL trcd_ok: got v=%0b rd=%0d want v=0 rd=1", err_valid, cnt_rd);
    end
  endtask

  task automatic test_trp();
    do_reset();
    step(CMD_ACT, 2'd0, 1'b0, 1'b0, 1'b1);
    nop(4);
    step(CMD_PRE, 2'd2, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bank_open !== 4'b0000 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL trp_preall: got open=%b v=%0b want open=0000 v=0", bank_open, err_valid);
    end
    nop(1);
    step(CMD_ACT, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd4 || err_bank !== 2'd0 || bank_open !== 4'b0000) begin
      failures++;
      $display("FAIL trp_early: got v=%0b code=%0d bank=%0d open=%b want v=1 code=4 bank=0 open=0000",
               err_valid, err_code, err_bank, bank_open);
    end
    step(CMD_ACT, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b0 || bank_open !== 4'b0001) begin
      failures++;
      $display("FAIL trp_ok: got v=%0b open=%b want v=0 open=0001", err_valid, bank_open);
    end
    step(CMD_ACT, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd3 || err_bank !== 2'd0) begin
      failures++;
      $display("FAIL already_open: got v=%0b code=%0d bank=%0d want v=1 code=3 bank=0",
               err_valid, err_code, err_bank);
    end
    step(CMD_PRE, 2'd1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b0 || bank_open !== 4'b0001) begin
      failures++;
      $display("FAIL pre_idle: got v=%0b open=%b want v=0 open=0001", err_valid, bank_open);
    end
    step(CMD_WR, 2'd2, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd1 || err_bank !== 2'd2) begin
      failures++;
      $display("FAIL not_open: got v=%0b code=%0d bank=%0d want v=1 code=1 bank=2",
               err_valid, err_code, err_bank);
    end
    checks++;
    if (err_sticky !== 7'b0001101 || cnt_act !== 16'd4 || cnt_wr !== 16'd1) begin
      failures++;
      $display("FAIL trp_totals: got sticky=%b act=%0d wr=%0d want sticky=0001101 act=4 wr=1",
               err_sticky, cnt_act, cnt_wr);
    end
  endtask

  task automatic test_not_idle();
    do_reset();
    step(CMD_ACT, 2'd2, 1'b0, 1'b0, 1'b1);
    nop(3);
    step(CMD_REF, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd5 || err_bank !== 2'd2) begin
      failures++;
      $display("FAIL not_idle: got v=%0b code=%0d bank=%0d want v=1 code=5 bank=2",
               err_valid, err_code, err_bank);
    end
    checks++;
    if (err_sticky !== 7'b0010000 || bank_open !== 4'b0100 || cnt_ref !== 16'd1) begin
      failures++;
      $display("FAIL not_idle_state: got sticky=%b open=%b ref=%0d want sticky=0010000 open=0100 ref=1",
               err_sticky, bank_open, cnt_ref);
    end
  endtask

  task automatic test_trfc();
    do_reset();
    step(CMD_REF, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b0 || cnt_ref !== 16'd1) begin
      failures++;
      $display("FAIL ref_ok: got v=%0b ref=%0d want v=0 ref=1", err_valid, cnt_ref);
    end
    step(CMD_RD, 2'd1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd6 || err_bank !== 2'd0) begin
      failures++;
      $display("FAIL trfc_mask: got v=%0b code=%0d bank=%0d want v=1 code=6 bank=0",
               err_valid, err_code, err_bank);
    end
    nop(4);
    step(CMD_ACT, 2'd3, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd6 || err_bank !== 2'd0 || bank_open !== 4'b0000) begin
      failures++;
      $display("FAIL trfc_last: got v=%0b code=%0d bank=%0d open=%b want v=1 code=6 bank=0 open=0000",
               err_valid, err_code, err_bank, bank_open);
    end
    step(CMD_ACT, 2'd3, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_valid !== 1'b0 || bank_open !== 4'b1000 || err_sticky !== 7'b0100000) begin
      failures++;
      $display("FAIL trfc_after: got v=%0b open=%b sticky=%b want v=0 open=1000 sticky=0100000",
               err_valid, bank_open, err_sticky);
    end
  endtask

  task automatic test_ref_late();
    int n_pulse;
    int pulse_at;
    logic [2:0] pulse_code;
    do_reset();
    n_pulse = 0;
    pulse_at = -1;
    pulse_code = '0;
    for (int n = 1; n <= 1600; n++) begin
      @(posedge sdram_clk);
      #1;
      if (err_valid) begin
        n_pulse++;
        if (pulse_at < 0) begin
          pulse_at = n;
          pulse_code = err_code;
        end
      end
    end
    checks++;
    if (n_pulse !== 1 || pulse_at !== 1560 || pulse_code !== 3'd7) begin
      failures++;
      $display("FAIL ref_late: got pulses=%0d at=%0d code=%0d want pulses=1 at=1560 code=7",
               n_pulse, pulse_at, pulse_code);
    end
    checks++;
    if (err_sticky !== 7'b1000000) begin
      failures++;
      $display("FAIL ref_late_sticky: got %b want 1000000", err_sticky);
    end
    step(CMD_REF, 2'd0, 1'b0, 1'b0, 1'b1);
    n_pulse = 0;
    pulse_at = -1;
    for (int n = 1; n <= 1600; n++) begin
      @(posedge sdram_clk);
      #1;
      if (err_valid) begin
        n_pulse++;
        if (pulse_at < 0) pulse_at = n;
      end
    end
    checks++;
    if (n_pulse !== 1 || pulse_at !== 1560) begin
      failures++;
      $display("FAIL ref_clear: got pulses=%0d at=%0d want pulses=1 at=1560", n_pulse, pulse_at);
    end
    step(CMD_NOP, 2'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (err_sticky !== 7'b0000000) begin
      failures++;
      $display("FAIL clr_sticky: got %b want 0000000", err_sticky);
    end
  endtask

  task automatic test_clr();
    do_reset();
    step(CMD_ACT, 2'd0, 1'b0, 1'b0, 1'b1);
    nop(2);
    step(CMD_WR, 2'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (cnt_wr !== 16'd0 || cnt_act !== 16'd0 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_wr: got wr=%0d act=%0d v=%0b want wr=0 act=0 v=0",
               cnt_wr, cnt_act, err_valid);
    end
    step(CMD_WR, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cnt_wr !== 16'd1) begin
      failures++;
      $display("FAIL wr_count: got %0d want 1", cnt_wr);
    end
    step(CMD_WR, 2'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt_wr !== 16'd1 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL deselect: got wr=%0d v=%0b want wr=1 v=0", cnt_wr, err_valid);
    end
    step(CMD_WR, 2'd3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd1 || err_bank !== 2'd3 ||
        err_sticky !== 7'b0000000 || cnt_wr !== 16'd0) begin
      failures++;
      $display("FAIL clr_err: got v=%0b code=%0d bank=%0d sticky=%b wr=%0d want v=1 code=1 bank=3 sticky=0 wr=0",
               err_valid, err_code, err_bank, err_sticky, cnt_wr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(CMD_ACT, 2'd1, 1'b0, 1'b0, 1'b1);
    repeat (299) step(CMD_ACT, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cnt_act !== 16'd300 || bank_open !== 4'b0011) begin
      failures++;
      $display("FAIL act_300: got act=%0d open=%b want act=300 open=0011", cnt_act, bank_open);
    end
    @(negedge sdram_clk);
    #1 sdram_resetn = 1'b0;
    #1;
    checks++;
    if ({err_valid, err_code, err_bank, err_sticky, bank_open} !== 17'd0 ||
        {cnt_act, cnt_rd, cnt_wr, cnt_ref} !== 64'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%0b code=%0d open=%b act=%0d want all 0",
               err_valid, err_code, bank_open, cnt_act);
    end
  endtask

  initial begin
    test_reset();
    test_trcd();
    test_trp();
    test_not_idle();
    test_trfc();
    test_ref_late();
    test_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
